// File: rtl/data16_10_pkg.sv
// Q8.8 classifier constants: trained weights/biases, fraction width, FSM state type.
// Latency: n/a (compile-time constants only).
// Backpressure: n/a.
package data16_10;

    localparam int FRAC_BITS = 8;
    localparam int N_IN_DEF  = 16;
    localparam int N_OUT_DEF = 10;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MAC  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    typedef logic [N_OUT_DEF-1:0][N_IN_DEF-1:0][15:0] weights_t;
    typedef logic [N_OUT_DEF-1:0][15:0]               biases_t;

    // Deterministic stand-in for the trained weights: small signed Q8.8
    // values (about +/-0.47) spread over both signs.
    function automatic weights_t gen_weights();
        weights_t w;
        for (int j = 0; j < N_OUT_DEF; j++) begin
            for (int i = 0; i < N_IN_DEF; i++) begin
                w[j][i] = 16'((((j * 7 + i * 13) % 31) - 15) * 8);
            end
        end
        return w;
    endfunction

    // Every class biased to -1.0 except class 4 at -0.5.
    function automatic biases_t gen_biases();
        biases_t b;
        for (int j = 0; j < N_OUT_DEF; j++) begin
            b[j] = 16'hFF00;
        end
        b[4] = 16'hFF80;
        return b;
    endfunction

    localparam weights_t finalWeights = gen_weights();
    localparam biases_t  finalBiases  = gen_biases();

endpackage

// File: rtl/output_classifier_sat_mac.sv
// Saturating Q8.8 MAC lane: 16x16 product into a 40-bit accumulator, floor shift, clamp to 16 bits.
// Latency: score is combinational from the current product; accumulator updates on each enabled edge.
// Backpressure: none; the caller gates accumulation with en.
// Ports: en advances the accumulator, first seeds it from bias instead of the running sum,
//        a/b are the Q8.8 operands, score is the saturated class score including this product.
module sat_mac #(
    parameter int ACC_W     = 40,
    parameter int FRAC_BITS = data16_10::FRAC_BITS
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic        first,
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic [15:0] bias,
    output logic [15:0] score
);

    logic signed [31:0]      a_ext;
    logic signed [31:0]      b_ext;
    logic signed [31:0]      prod;
    logic signed [ACC_W-1:0] base;
    logic signed [ACC_W-1:0] sum;
    logic signed [ACC_W-1:0] shifted;
    logic signed [ACC_W-1:0] acc;
    logic [ACC_W-16:0]       hi;

    always_comb begin
        a_ext   = {{16{a[15]}}, a};
        b_ext   = {{16{b[15]}}, b};
        prod    = a_ext * b_ext;
        // The first product of a class starts from the bias scaled to the
        // product's Q16.16 alignment rather than from the stale accumulator.
        base    = first ? ({{(ACC_W-16){bias[15]}}, bias} <<< FRAC_BITS) : acc;
        sum     = base + {{(ACC_W-32){prod[31]}}, prod};
        shifted = sum >>> FRAC_BITS;
        // In range exactly when bits [ACC_W-1:15] are all copies of the sign.
        hi      = shifted[ACC_W-1:15];
        if ((&hi) || (~|hi)) begin
            score = shifted[15:0];
        end else if (shifted[ACC_W-1]) begin
            score = 16'h8000;
        end else begin
            score = 16'h7FFF;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc <= '0;
        end else if (en) begin
            acc <= sum;
        end
    end

endmodule

// File: rtl/output_classifier.sv
// Final dense layer + argmax: one MAC per cycle over N_OUT x N_IN, then presents class index and scores.
// Latency: out_valid registered on the last of N_IN*N_OUT MAC edges after the capture edge.
// Backpressure: result held stable until out_ready; in_valid outside IDLE is dropped and pulses overrun.
// Ports: in_valid/in_data frame input (accepted only while in_ready), out_valid/out_ready result
//        handshake, class_idx/class_score winning class, scores all saturated class scores.
module output_classifier
    import data16_10::*;
#(
    parameter int N_IN      = 16,
    parameter int N_OUT     = 10,
    parameter int FRAC_BITS = data16_10::FRAC_BITS,
    parameter logic [N_OUT-1:0][N_IN-1:0][15:0] WEIGHTS = data16_10::finalWeights,
    parameter logic [N_OUT-1:0][15:0]            BIASES  = data16_10::finalBiases
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    input  logic [N_IN-1:0][15:0]      in_data,
    output logic                       in_ready,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [3:0]                 class_idx,
    output logic [15:0]                class_score,
    output logic [N_OUT-1:0][15:0]     scores,
    output logic                       overrun
);

    localparam int IW = (N_IN  > 1) ? $clog2(N_IN)  : 1;
    localparam int JW = (N_OUT > 1) ? $clog2(N_OUT) : 1;

    state_t                  state;
    logic [N_IN-1:0][15:0]   frame;
    logic [IW-1:0]           i_cnt;
    logic [JW-1:0]           j_cnt;
    logic                    last_i;
    logic                    last_j;
    logic                    better;
    logic [15:0]             mac_score;

    assign last_i = (i_cnt == IW'(N_IN - 1));
    assign last_j = (j_cnt == JW'(N_OUT - 1));
    // Strict greater-than keeps the lower index on ties; class 0 always seeds.
    assign better = (j_cnt == '0) || ($signed(mac_score) > $signed(class_score));

    sat_mac #(
        .ACC_W     (40),
        .FRAC_BITS (FRAC_BITS)
    ) u_sat_mac (
        .clk   (clk),
        .reset (reset),
        .en    (state == S_MAC),
        .first (i_cnt == '0),
        .a     (frame[i_cnt]),
        .b     (WEIGHTS[j_cnt][i_cnt]),
        .bias  (BIASES[j_cnt]),
        .score (mac_score)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= S_IDLE;
            in_ready    <= 1'b1;
            out_valid   <= 1'b0;
            overrun     <= 1'b0;
            class_idx   <= '0;
            class_score <= '0;
            scores      <= '0;
            frame       <= '0;
            i_cnt       <= '0;
            j_cnt       <= '0;
        end else begin
            // Any frame offered outside IDLE is lost, including one that
            // coincides with the DONE acceptance.
            overrun <= in_valid && (state != S_IDLE);
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        frame    <= in_data;
                        i_cnt    <= '0;
                        j_cnt    <= '0;
                        in_ready <= 1'b0;
                        state    <= S_MAC;
                    end
                end
                S_MAC: begin
                    if (last_i) begin
                        scores[j_cnt] <= mac_score;
                        if (better) begin
                            class_score <= mac_score;
                            class_idx   <= 4'(j_cnt);
                        end
                        i_cnt <= '0;
                        if (last_j) begin
                            j_cnt     <= '0;
                            out_valid <= 1'b1;
                            state     <= S_DONE;
                        end else begin
                            j_cnt <= j_cnt + 1'b1;
                        end
                    end else begin
                        i_cnt <= i_cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_output_classifier.sv
// Bench: four classifier instances with different weight sets share one stimulus stream.
// Instance 0 uses the package weights/biases, 1 uniform 0x0100, 2 one-hot [7][0], 3 all 0x7FFF.
// Cycle counting: the capture edge is cycle 1, so out_valid is first seen in cycle 161.
module tb_output_classifier;
    import data16_10::*;

    localparam int NI   = 4;
    localparam int NIN  = 16;
    localparam int NOUT = 10;
    localparam int LAT  = 161;

    function automatic weights_t hot_weights();
        weights_t w;
        w       = '0;
        w[7][0] = 16'h0100;
        return w;
    endfunction

    localparam weights_t W_UNI  = {160{16'h0100}};
    localparam weights_t W_SAT  = {160{16'h7FFF}};
    localparam weights_t W_HOT  = hot_weights();
    localparam biases_t  B_ZERO = '0;

    logic                   clk = 1'b0;
    logic                   reset = 1'b0;
    logic                   in_valid = 1'b0;
    logic                   out_ready = 1'b0;
    logic [NIN-1:0][15:0]   in_data = '0;

    logic                   rdy_o  [NI];
    logic                   vld_o  [NI];
    logic                   orun_o [NI];
    logic [3:0]             idx_o  [NI];
    logic [15:0]            cs_o   [NI];
    logic [NOUT-1:0][15:0]  sc_o   [NI];

    logic [3:0]             snap_idx [NI];
    logic [15:0]            snap_cs  [NI];
    logic [NOUT-1:0][15:0]  snap_sc  [NI];

    weights_t wt [NI];
    biases_t  bt [NI];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    output_classifier u_main (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .in_ready(rdy_o[0]),
        .out_valid(vld_o[0]), .out_ready(out_ready), .class_idx(idx_o[0]), .class_score(cs_o[0]),
        .scores(sc_o[0]), .overrun(orun_o[0]));

    output_classifier #(.WEIGHTS(W_UNI), .BIASES(B_ZERO)) u_uni (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .in_ready(rdy_o[1]),
        .out_valid(vld_o[1]), .out_ready(out_ready), .class_idx(idx_o[1]), .class_score(cs_o[1]),
        .scores(sc_o[1]), .overrun(orun_o[1]));

    output_classifier #(.WEIGHTS(W_HOT), .BIASES(B_ZERO)) u_hot (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .in_ready(rdy_o[2]),
        .out_valid(vld_o[2]), .out_ready(out_ready), .class_idx(idx_o[2]), .class_score(cs_o[2]),
        .scores(sc_o[2]), .overrun(orun_o[2]));

    output_classifier #(.WEIGHTS(W_SAT), .BIASES(B_ZERO)) u_sat (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .in_ready(rdy_o[3]),
        .out_valid(vld_o[3]), .out_ready(out_ready), .class_idx(idx_o[3]), .class_score(cs_o[3]),
        .scores(sc_o[3]), .overrun(orun_o[3]));

    // Reference: exact integer dot product, floor division by 256, clamp, first-max argmax.
    task automatic model(input int k, input logic [NIN-1:0][15:0] d,
                         output logic [NOUT-1:0][15:0] sc, output logic [3:0] idx,
                         output logic [15:0] best);
        longint acc;
        longint q;
        for (int j = 0; j < NOUT; j++) begin
            acc = longint'($signed(bt[k][j])) * 256;
            for (int i = 0; i < NIN; i++) begin
                acc += longint'($signed(d[i])) * longint'($signed(wt[k][j][i]));
            end
            q = acc / 256;
            if (acc < 0 && (acc % 256) != 0) q = q - 1;
            if (q > 32767) q = 32767;
            else if (q < -32768) q = -32768;
            sc[j] = 16'(q);
        end
        idx  = 4'd0;
        best = sc[0];
        for (int j = 1; j < NOUT; j++) begin
            if ($signed(sc[j]) > $signed(best)) begin
                best = sc[j];
                idx  = 4'(j);
            end
        end
    endtask

    function automatic logic [NIN-1:0][15:0] rand_frame(input int maxv);
        logic [NIN-1:0][15:0] d;
        for (int i = 0; i < NIN; i++) d[i] = 16'($urandom_range(0, maxv));
        return d;
    endfunction

    // Drives one frame and snapshots every instance's result in the out_valid cycle.
    task automatic run_frame(input logic [NIN-1:0][15:0] d, input int hold, input bit inject,
                             output int lat, output int ovr, output int unstable,
                             output int rdy_bad, output bit acc_ok);
        lat = -1; ovr = 0; unstable = 0; rdy_bad = 0; acc_ok = 1'b0;
        @(negedge clk);
        in_data = d; in_valid = 1'b1; out_ready = 1'b0;
        for (int c = 1; c <= 400; c++) begin
            @(negedge clk);
            ovr += int'(orun_o[0]);
            if (rdy_o[0] !== 1'b0) rdy_bad++;
            if (vld_o[0] === 1'b1) begin
                lat = c;
                break;
            end
            if (inject && c == 50) begin
                in_valid = 1'b1;
                in_data  = ~d;
            end else begin
                in_valid = 1'b0;
            end
        end
        in_valid = 1'b0;
        if (lat < 0) return;
        for (int k = 0; k < NI; k++) begin
            snap_idx[k] = idx_o[k];
            snap_cs[k]  = cs_o[k];
            snap_sc[k]  = sc_o[k];
        end
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            ovr += int'(orun_o[0]);
            if (rdy_o[0] !== 1'b0) rdy_bad++;
            for (int k = 0; k < NI; k++) begin
                if ({vld_o[k], idx_o[k], cs_o[k], sc_o[k]} !==
                    {1'b1, snap_idx[k], snap_cs[k], snap_sc[k]}) unstable++;
            end
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        ovr += int'(orun_o[0]);
        acc_ok = (vld_o[0] === 1'b0) && (rdy_o[0] === 1'b1);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        for (int k = 0; k < NI; k++) begin
            checks++;
            if ({rdy_o[k], vld_o[k], orun_o[k], idx_o[k], cs_o[k], sc_o[k]} !== {3'b100, 180'h0}) begin
                failures++;
                $display("FAIL reset_state k=%0d got rdy=%b vld=%b ovr=%b idx=%h cs=%h sc=%h exp rdy=1 others 0",
                         k, rdy_o[k], vld_o[k], orun_o[k], idx_o[k], cs_o[k], sc_o[k]);
            end
        end
        reset = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_known_vectors();
        logic [NIN-1:0][15:0]  d;
        logic [NOUT-1:0][15:0] esc;
        logic [3:0]            eidx;
        logic [15:0]           ecs;
        int k, lat, ovr, unst, rb;
        bit ok;
        for (int v = 0; v < 4; v++) begin
            d = '0;
            case (v)
                0: begin for (int i = 0; i < NIN; i++) d[i] = 16'h0100;
                         k = 1; esc = {NOUT{16'h1000}}; eidx = 4'd0; ecs = 16'h1000; end
                1: begin d[0] = 16'h0300;
                         k = 2; esc = '0; esc[7] = 16'h0300; eidx = 4'd7; ecs = 16'h0300; end
                2: begin for (int i = 0; i < NIN; i++) d[i] = 16'h7FFF;
                         k = 3; esc = {NOUT{16'h7FFF}}; eidx = 4'd0; ecs = 16'h7FFF; end
                default: begin
                         k = 0; esc = {NOUT{16'hFF00}}; esc[4] = 16'hFF80; eidx = 4'd4; ecs = 16'hFF80; end
            endcase
            run_frame(d, 0, 1'b0, lat, ovr, unst, rb, ok);
            checks++;
            if (lat != LAT) begin
                failures++;
                $display("FAIL vec%0d_latency got=%0d exp=%0d", v, lat, LAT);
            end
            checks++;
            if (snap_sc[k] !== esc) begin
                failures++;
                $display("FAIL vec%0d_scores got=%h exp=%h", v, snap_sc[k], esc);
            end
            checks++;
            if ({snap_idx[k], snap_cs[k]} !== {eidx, ecs}) begin
                failures++;
                $display("FAIL vec%0d_argmax got idx=%0d cs=%h exp idx=%0d cs=%h",
                         v, snap_idx[k], snap_cs[k], eidx, ecs);
            end
        end
    endtask

    task automatic test_random_back_to_back();
        logic [NIN-1:0][15:0]  d;
        logic [NOUT-1:0][15:0] esc;
        logic [3:0]            eidx;
        logic [15:0]           ecs;
        int lat, ovr, unst, rb;
        bit ok;
        for (int f = 0; f < 6; f++) begin
            d = rand_frame((f % 2 == 1) ? 32'h7FFF : 32'h03FF);
            run_frame(d, int'($urandom_range(0, 3)), 1'b0, lat, ovr, unst, rb, ok);
            checks++;
            if (lat != LAT || ovr != 0 || unst != 0 || rb != 0 || !ok) begin
                failures++;
                $display("FAIL rand%0d_handshake got lat=%0d ovr=%0d unstable=%0d rdy_bad=%0d acc=%0d exp %0d/0/0/0/1",
                         f, lat, ovr, unst, rb, ok, LAT);
            end
            for (int k = 0; k < NI; k++) begin
                model(k, d, esc, eidx, ecs);
                checks++;
                if (snap_sc[k] !== esc) begin
                    failures++;
                    $display("FAIL rand%0d_scores k=%0d got=%h exp=%h", f, k, snap_sc[k], esc);
                end
                checks++;
                if ({snap_idx[k], snap_cs[k]} !== {eidx, ecs}) begin
                    failures++;
                    $display("FAIL rand%0d_argmax k=%0d got idx=%0d cs=%h exp idx=%0d cs=%h",
                             f, k, snap_idx[k], snap_cs[k], eidx, ecs);
                end
            end
        end
    endtask

    task automatic test_overrun_backpressure();
        logic [NIN-1:0][15:0]  d;
        logic [NOUT-1:0][15:0] esc;
        logic [3:0]            eidx;
        logic [15:0]           ecs;
        int lat, ovr, unst, rb;
        bit ok;
        d = rand_frame(32'h01FF);
        run_frame(d, 20, 1'b1, lat, ovr, unst, rb, ok);
        checks++;
        if (lat != LAT) begin failures++; $display("FAIL ovr_latency got=%0d exp=%0d", lat, LAT); end
        checks++;
        if (ovr != 1) begin failures++; $display("FAIL ovr_pulses got=%0d exp=1", ovr); end
        checks++;
        if (unst != 0) begin failures++; $display("FAIL hold_stable unstable_cycles got=%0d exp=0", unst); end
        checks++;
        if (rb != 0 || !ok) begin
            failures++;
            $display("FAIL in_ready_timing got bad_cycles=%0d accepted=%0d exp 0/1", rb, ok);
        end
        for (int k = 0; k < NI; k++) begin
            model(k, d, esc, eidx, ecs);
            checks++;
            if ({snap_idx[k], snap_cs[k], snap_sc[k]} !== {eidx, ecs, esc}) begin
                failures++;
                $display("FAIL ovr_result k=%0d got idx=%0d cs=%h sc=%h exp idx=%0d cs=%h sc=%h",
                         k, snap_idx[k], snap_cs[k], snap_sc[k], eidx, ecs, esc);
            end
        end
    endtask

    task automatic test_done_collision();
        logic [NIN-1:0][15:0] d;
        int lat;
        d = rand_frame(32'h00FF);
        lat = -1;
        @(negedge clk);
        in_data = d; in_valid = 1'b1; out_ready = 1'b0;
        for (int c = 1; c <= 400; c++) begin
            @(negedge clk);
            in_valid = 1'b0;
            if (vld_o[0] === 1'b1) begin lat = c; break; end
        end
        checks++;
        if (lat != LAT) begin failures++; $display("FAIL coll_latency got=%0d exp=%0d", lat, LAT); end
        in_valid = 1'b1; in_data = ~d; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b0;
        checks++;
        if ({orun_o[0], rdy_o[0], vld_o[0]} !== 3'b110) begin
            failures++;
            $display("FAIL coll_accept got ovr/rdy/vld=%b%b%b exp=110", orun_o[0], rdy_o[0], vld_o[0]);
        end
        repeat (3) @(negedge clk);
        checks++;
        if ({orun_o[0], rdy_o[0], vld_o[0]} !== 3'b010) begin
            failures++;
            $display("FAIL coll_dropped got ovr/rdy/vld=%b%b%b exp=010", orun_o[0], rdy_o[0], vld_o[0]);
        end
    endtask

    task automatic test_reset_mid();
        logic [NIN-1:0][15:0]  d;
        logic [NOUT-1:0][15:0] esc;
        logic [3:0]            eidx;
        logic [15:0]           ecs;
        int lat, ovr, unst, rb;
        bit ok;
        d = rand_frame(32'h0FFF);
        @(negedge clk);
        in_data = d; in_valid = 1'b1;
        for (int c = 1; c <= 80; c++) begin
            @(negedge clk);
            in_valid = 1'b0;
        end
        reset = 1'b0;
        #1;
        for (int k = 0; k < NI; k++) begin
            checks++;
            if ({rdy_o[k], vld_o[k], orun_o[k], idx_o[k], cs_o[k], sc_o[k]} !== {3'b100, 180'h0}) begin
                failures++;
                $display("FAIL midreset_state k=%0d got rdy=%b vld=%b ovr=%b idx=%h cs=%h sc=%h exp rdy=1 others 0",
                         k, rdy_o[k], vld_o[k], orun_o[k], idx_o[k], cs_o[k], sc_o[k]);
            end
        end
        @(negedge clk);
        reset = 1'b1;
        d = rand_frame(32'h07FF);
        run_frame(d, 0, 1'b0, lat, ovr, unst, rb, ok);
        checks++;
        if (lat != LAT) begin failures++; $display("FAIL midreset_latency got=%0d exp=%0d", lat, LAT); end
        for (int k = 0; k < NI; k++) begin
            model(k, d, esc, eidx, ecs);
            checks++;
            if ({snap_idx[k], snap_cs[k], snap_sc[k]} !== {eidx, ecs, esc}) begin
                failures++;
                $display("FAIL midreset_result k=%0d got idx=%0d cs=%h sc=%h exp idx=%0d cs=%h sc=%h",
                         k, snap_idx[k], snap_cs[k], snap_sc[k], eidx, ecs, esc);
            end
        end
    endtask

    initial begin
        wt[0] = finalWeights; bt[0] = finalBiases;
        wt[1] = W_UNI;        bt[1] = B_ZERO;
        wt[2] = W_HOT;        bt[2] = B_ZERO;
        wt[3] = W_SAT;        bt[3] = B_ZERO;
        test_reset();
        test_known_vectors();
        test_random_back_to_back();
        test_overrun_backpressure();
        test_done_collision();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "simulation time limit");
    end

endmodule

// File: doc/output_classifier.md
OUTPUT_CLASSIFIER -- requirements
Module: output_classifier

Interface
REQ-001 Parameter N_IN, 16, number of activations per frame from the preceding dense stage.
REQ-002 Parameter N_OUT, 10, number of output classes.
REQ-003 Parameter FRAC_BITS, 8, fractional bits of the Q8.8 signed data format.
REQ-004 Parameter WEIGHTS, data16_10::finalWeights, signed 16-bit [N_OUT][N_IN] weight array in Q8.8.
REQ-005 Parameter BIASES, data16_10::finalBiases, signed 16-bit [N_OUT] bias array in Q8.8.
REQ-006 clk  input  1  single clock; all state is updated on its rising edge.
REQ-007 reset  input  1  asynchronous, active-low reset.
REQ-008 in_valid  input  1  one-cycle pulse marking a new activation frame on in_data.
REQ-009 in_data  input  16 x N_IN signed  post-ReLU activations from the upstream dense stage.
REQ-010 in_ready  output  1  high only in IDLE.
REQ-011 out_valid  output  1  result available; held until accepted.
REQ-012 out_ready  input  1  consumer accepts the result when high together with out_valid.
REQ-013 class_idx  output  4  argmax class index.
REQ-014 class_score  output  16 signed  score of the winning class.
REQ-015 scores  output  16 x N_OUT signed  all saturated class scores.
REQ-016 overrun  output  1  one-cycle pulse when in_valid arrives while in_ready is low.

Function
REQ-017 The FSM SHALL have the states IDLE, MAC and DONE.
- IDLE->MAC on in_valid, capturing in_data into an internal frame buffer.
- MAC->DONE after the last product of class N_OUT-1.
- DONE->IDLE on out_valid && out_ready.
REQ-018 MAC SHALL perform exactly one multiply-accumulate per cycle, iterating input i (0..N_IN-1) within class j (0..N_OUT-1); total N_IN*N_OUT = 160 cycles.
REQ-019 Accumulation rules:
- Each class accumulator is a 40-bit signed register, preloaded with BIASES[j] <<< FRAC_BITS.
- Each product is a full 32-bit signed product.
REQ-020 On the cycle with i == N_IN-1, the class score SHALL be computed as (acc >>> FRAC_BITS), saturated to [-32768, 32767], and written to scores[j].
REQ-021 Argmax rules:
- Argmax is updated in that same cycle using strict greater-than, so ties keep the lower index.
- Class 0 always initialises the best value.
REQ-022 out_valid SHALL rise exactly 161 cycles after the capture edge (capture edge plus 160 MAC cycles), with class_idx, class_score and scores valid in that cycle.
REQ-023 While out_valid is high and out_ready is low, all outputs SHALL hold stable.
REQ-024 in_valid arriving in MAC or DONE SHALL be dropped, SHALL pulse overrun, and SHALL NOT disturb the frame in progress.
REQ-025 If in_valid and the out_ready acceptance occur in the same DONE cycle, the frame SHALL be dropped with overrun, and the FSM SHALL return to IDLE only.
REQ-026 No ReLU SHALL be applied to scores; negative scores are valid results.

Reset
REQ-027 When reset is low, reset SHALL take effect immediately, independent of clk, in any state, including mid-MAC.
REQ-028 Reset values:
- FSM returns to IDLE.
- in_ready = 1.
- out_valid, overrun, class_idx, class_score and all scores = 0.
- Counters and accumulator cleared.
- Any partial frame discarded.
REQ-029 The first in_valid accepted after reset deassertion SHALL be the first cycle-accurate frame.

Structure
REQ-030 Package data16_10 SHALL hold finalWeights, finalBiases, the Q8.8 FRAC_BITS constant and the state enum type.
REQ-031 The saturating MAC datapath (multiply, 40-bit accumulate, round-down shift, saturate) SHALL be one sub-module, sat_mac; the FSM, counters, frame buffer and argmax SHALL stay in output_classifier.

Verification
REQ-032 Uniform frame:
- Stimulus: all WEIGHTS = 16'h0100, BIASES = 0, in_data all 16'h0100.
- Required response: every score = 16'h1000, class_idx = 0 (tie rule), out_valid at exactly cycle 161.
REQ-033 One-hot weights:
- Stimulus: WEIGHTS[7][0] = 16'h0100, all other weights 0, BIASES = 0, in_data[0] = 16'h0300, others 0.
- Required response: class_idx = 7, class_score = 16'h0300.
REQ-034 Saturation:
- Stimulus: all weights and in_data = 16'h7FFF.
- Required response: all scores = 16'h7FFF, class_idx = 0.
REQ-035 All-negative scores:
- Stimulus: in_data all 0, BIASES all 16'hFF00 except BIASES[4] = 16'hFF80.
- Required response: class_idx = 4, class_score = 16'hFF80.
REQ-036 Overrun and backpressure:
- Stimulus: in_valid pulse at MAC cycle 50; out_ready held low for 20 cycles after out_valid.
- Required response: one overrun pulse; result identical to the unperturbed frame; outputs stable for all 20 cycles; in_ready low until the cycle after acceptance.
REQ-037 Reset mid-operation:
- Stimulus: reset asserted at MAC cycle 80.
- Required response: immediate IDLE with all outputs 0; a following frame produces correct results with 161-cycle latency.
